// File: rtl/z_n_css_seq_pkg.sv
// Shared definitions for the z_n carry-select subtractor: FSM encodings and slice-count helper.
package z_n_css_seq_pkg;

    // State encodings kept numerically identical to the z_n_csa family.
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] S_IDLE = 2'd0;
    localparam logic [STATE_W-1:0] S_CALC = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE = 2'd2;

    // Number of compute cycles for a WIDTH-bit operation done CHUNK bits at a time.
    function automatic int unsigned num_slices(input int unsigned width,
                                               input int unsigned chunk);
        return width / chunk;
    endfunction

    // Counter width able to hold a slice index; never zero bits, even when N == 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/z_n_css_slice.sv
// Combinational CHUNK-bit dual-path subtract slice: both borrow-in cases, selected by bin.
module z_n_css_slice #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_s,
    input  logic [CHUNK-1:0] b_s,
    input  logic             bin,
    output logic [CHUNK-1:0] d_s,
    output logic             bout
);

    logic [CHUNK:0] r0;
    logic [CHUNK:0] r1;
    logic [CHUNK:0] sel;

    // Precompute borrow-in 0 and 1 results; the extra MSB is the slice borrow-out.
    always_comb begin
        r0   = {1'b0, a_s} - {1'b0, b_s};
        r1   = r0 - 1'b1;
        sel  = bin ? r1 : r0;
        d_s  = sel[CHUNK-1:0];
        bout = sel[CHUNK];
    end

endmodule

// File: rtl/z_n_css_seq.sv
// Sequential carry-select subtractor: diff = a - b - b_in, one CHUNK slice per clock,
// LSB slice first, behind valid/ready handshakes on both sides.
module z_n_css_seq
    import z_n_css_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             b_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             b_out,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned N    = num_slices(WIDTH, CHUNK);
    localparam int unsigned IDXW = idx_width(N);
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [IDXW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               b_out_q, b_out_d;
    logic               ovf_q, ovf_d;

    logic [CHUNK-1:0]   slice_a;
    logic [CHUNK-1:0]   slice_b;
    logic [CHUNK-1:0]   slice_d;
    logic               slice_bout;

    // Pick the operand slice addressed by the running index.
    always_comb begin
        slice_a = a_q[idx_q*CHUNK +: CHUNK];
        slice_b = b_q[idx_q*CHUNK +: CHUNK];
    end

    z_n_css_slice #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_s  (slice_a),
        .b_s  (slice_b),
        .bin  (borrow_q),
        .d_s  (slice_d),
        .bout (slice_bout)
    );

    // FSM and datapath next-state: accept in IDLE, one slice per CALC edge, hold in DONE.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    borrow_d = b_in;
                    idx_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d[idx_q*CHUNK +: CHUNK] = slice_d;
                borrow_d = slice_bout;
                idx_d    = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    // Publish the full result; acc_d already includes the top slice.
                    diff_d  = acc_d;
                    b_out_d = slice_bout;
                    ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset also aborts any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            idx_q    <= '0;
            acc_q    <= '0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    // Handshake flags follow directly from the state; result registers drive the outputs.
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
        diff      = diff_q;
        b_out     = b_out_q;
        ovf       = ovf_q;
    end

endmodule

// File: tb/tb_z_n_css_seq.sv
// Directed self-checking bench for z_n_css_seq (WIDTH=8, CHUNK=4).
module tb_z_n_css_seq;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic       b_in;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] diff;
    logic       b_out;
    logic       ovf;
    logic       out_valid;
    logic       out_ready;

    int n_chk;
    int n_bad;

    z_n_css_seq #(
        .WIDTH (8),
        .CHUNK (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .b_in      (b_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .diff      (diff),
        .b_out     (b_out),
        .ovf       (ovf),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, check the exact 2-edge latency and the result, then drain it.
    task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb_,
                          input logic tbin, input logic [7:0] ed, input logic eb,
                          input logic eo);
        int lat;
        a = ta;
        b = tb_;
        b_in = tbin;
        in_valid = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        step();
        in_valid = 1'b0;
        chk({tag, ".busy"}, in_ready, 0);
        lat = 0;
        while (!out_valid && lat < 10) begin
            step();
            lat++;
        end
        chk({tag, ".latency"}, lat, 2);
        chk({tag, ".diff"}, diff, ed);
        chk({tag, ".b_out"}, b_out, eb);
        chk({tag, ".ovf"}, ovf, eo);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".drained"}, out_valid, 0);
        chk({tag, ".idle"}, in_ready, 1);
    endtask

    initial begin
        logic seen;
        n_chk = 0;
        n_bad = 0;
        rst = 1'b1;
        a = '0;
        b = '0;
        b_in = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.diff", diff, 0);
        chk("rst.b_out", b_out, 0);
        chk("rst.ovf", ovf, 0);

        run_op("ff_ff_1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op("3c_0f", 8'h3C, 8'h0F, 1'b0, 8'h2D, 1'b0, 1'b0);
        run_op("80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op("00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op("7f_80", 8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1);
        run_op("55_55_1", 8'h55, 8'h55, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Stall in DONE for 5 cycles with stray in_valid pulses.
        a = 8'h3C;
        b = 8'h0F;
        b_in = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        chk("stall.valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            a = 8'h11 * i[7:0];
            b = 8'hA0;
            b_in = i[0];
            in_valid = i[0];
            step();
            chk("stall.hold_valid", out_valid, 1);
            chk("stall.hold_diff", diff, 8'h2D);
            chk("stall.hold_bout", b_out, 0);
            chk("stall.in_ready", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("stall.exit_valid", out_valid, 0);
        chk("stall.exit_idle", in_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("stall.no_queue", seen, 0);

        // Reset one edge into CALC aborts the operation.
        a = 8'hFF;
        b = 8'hFF;
        b_in = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.diff", diff, 0);
        chk("abort.in_ready", in_ready, 1);
        chk("abort.valid", out_valid, 0);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort.no_result", seen, 0);

        // Back-to-back with in_valid held high.
        a = 8'h3C;
        b = 8'h0F;
        b_in = 1'b0;
        in_valid = 1'b1;
        step();
        a = 8'h80;
        b = 8'h01;
        step();
        step();
        chk("b2b.first_valid", out_valid, 1);
        chk("b2b.first_diff", diff, 8'h2D);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("b2b.gap_idle", in_ready, 1);
        chk("b2b.gap_valid", out_valid, 0);
        step();
        in_valid = 1'b0;
        chk("b2b.second_accept", in_ready, 0);
        step();
        chk("b2b.mid_valid", out_valid, 0);
        step();
        chk("b2b.second_valid", out_valid, 1);
        chk("b2b.second_diff", diff, 8'h7F);
        chk("b2b.second_ovf", ovf, 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("b2b.done", in_ready, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
